// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pkg : types shared by the FFT collector, core and serializer   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fft_pkg;

  localparam int FFT_NUM_POINTS = 8;
  localparam int FFT_SIZE_DATA  = 32;

  typedef logic [FFT_SIZE_DATA-1:0] sample_t;
  typedef sample_t [FFT_NUM_POINTS-1:0] frame_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    ACTIVE  = 2'd3
  } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_frame_bank : one frame of sample storage plus its bank state   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int NUM_POINTS = FFT_NUM_POINTS,
  parameter int SIZE_DATA  = FFT_SIZE_DATA,
  parameter int IDX_W      = $clog2(NUM_POINTS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [IDX_W-1:0]                     wr_idx,
  input  logic                                 wr_last,
  input  logic [SIZE_DATA-1:0]                 wr_data,
  input  logic                                 flush,
  input  logic                                 start,
  input  logic                                 done,
  output logic [NUM_POINTS-1:0][SIZE_DATA-1:0] frame,
  output bank_state_e                          state,
  output bank_state_e                          state_next
);

  // A bank completing and starting on the same edge skips FULL entirely.
  always_comb begin
    state_next = state;
    if (done && state == ACTIVE) begin
      state_next = EMPTY;
    end else if (flush && state == FILLING) begin
      state_next = EMPTY;
    end else if (wr_en) begin
      if (wr_last) begin
        state_next = start ? ACTIVE : FULL;
      end else begin
        state_next = FILLING;
      end
    end else if (start && state == FULL) begin
      state_next = ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      frame <= '0;
    end else begin
      state <= state_next;
      if (wr_en) begin
        frame[wr_idx] <= wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_sample_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_sample_collector : ping-pong frame assembler feeding FFT core  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fft_sample_collector
  import fft_pkg::*;
#(
  parameter int NUM_POINTS = FFT_NUM_POINTS,
  parameter int SIZE_DATA  = FFT_SIZE_DATA,
  parameter int CNT_W      = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_valid,
  input  logic [SIZE_DATA-1:0]                 i_sample,
  output logic                                 o_ready,
  input  logic                                 i_flush,
  input  logic                                 i_fft_done,
  output logic                                 o_start,
  output logic [NUM_POINTS-1:0][SIZE_DATA-1:0] o_data,
  output logic                                 o_busy,
  output logic [CNT_W-1:0]                     o_frame_cnt
);

  localparam int              IDX_W    = $clog2(NUM_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  logic                                 fill_ptr;
  logic [IDX_W-1:0]                     wr_idx;
  bank_state_e                          bank_st  [2];
  bank_state_e                          bank_nxt [2];
  logic [NUM_POINTS-1:0][SIZE_DATA-1:0] bank_frame [2];

  logic                                 accept;
  logic                                 last;
  logic                                 completes;
  logic                                 any_active;
  logic                                 done_eff;
  logic [1:0]                           pend_full;
  logic                                 start_now;
  logic                                 start_sel;
  logic                                 fill_ptr_next;
  logic [NUM_POINTS-1:0][SIZE_DATA-1:0] start_frame;
  logic                                 ready_next;
  logic                                 busy_next;

  always_comb begin
    accept        = i_valid & o_ready & ~i_flush;
    last          = (wr_idx == LAST_IDX);
    completes     = accept & last;
    any_active    = (bank_st[0] == ACTIVE) | (bank_st[1] == ACTIVE);
    // The core cannot finish a frame during the cycle it is being started.
    done_eff      = i_fft_done & ~o_start & any_active;
    pend_full[0]  = (bank_st[0] == FULL) | (completes & ~fill_ptr);
    pend_full[1]  = (bank_st[1] == FULL) | (completes &  fill_ptr);
    start_now     = (~any_active | done_eff) & (|pend_full);
    if (bank_st[0] == FULL) begin
      start_sel = 1'b0;
    end else if (bank_st[1] == FULL) begin
      start_sel = 1'b1;
    end else begin
      start_sel = fill_ptr;
    end
    fill_ptr_next = fill_ptr ^ completes;
    // A bank started on its completing edge still lacks the sample being written.
    start_frame   = bank_frame[start_sel];
    if (accept && (start_sel == fill_ptr)) begin
      start_frame[wr_idx] = i_sample;
    end
  end

  always_comb begin
    ready_next = (bank_nxt[fill_ptr_next] == EMPTY) | (bank_nxt[fill_ptr_next] == FILLING);
    busy_next  = (bank_nxt[0] == ACTIVE) | (bank_nxt[1] == ACTIVE);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);
    fft_frame_bank #(
      .NUM_POINTS (NUM_POINTS),
      .SIZE_DATA  (SIZE_DATA),
      .IDX_W      (IDX_W)
    ) u_bank (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .wr_en      (accept & (fill_ptr == SEL)),
      .wr_idx     (wr_idx),
      .wr_last    (last),
      .wr_data    (i_sample),
      .flush      (i_flush & (fill_ptr == SEL)),
      .start      (start_now & (start_sel == SEL)),
      .done       (done_eff),
      .frame      (bank_frame[b]),
      .state      (bank_st[b]),
      .state_next (bank_nxt[b])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_ptr    <= 1'b0;
      wr_idx      <= '0;
      o_ready     <= 1'b0;
      o_start     <= 1'b0;
      o_busy      <= 1'b0;
      o_data      <= '0;
      o_frame_cnt <= '0;
    end else begin
      fill_ptr <= fill_ptr_next;
      if (i_flush) begin
        wr_idx <= '0;
      end else if (accept) begin
        wr_idx <= last ? '0 : wr_idx + 1'b1;
      end
      o_ready <= ready_next;
      o_start <= start_now;
      o_busy  <= busy_next;
      if (start_now) begin
        o_data      <= start_frame;
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft_sample_collector : scenario tasks against a queue model     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fft_sample_collector;

  localparam int NP = 8;
  localparam int SD = 32;
  localparam int CW = 2;

  typedef logic [NP-1:0][SD-1:0] frm_t;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          i_valid    = 1'b0;
  logic [SD-1:0] i_sample   = '0;
  logic          i_flush    = 1'b0;
  logic          i_fft_done = 1'b0;
  logic          o_ready;
  logic          o_start;
  frm_t          o_data;
  logic          o_busy;
  logic [CW-1:0] o_frame_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_sample_collector #(
    .NUM_POINTS (NP),
    .SIZE_DATA  (SD),
    .CNT_W      (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_sample    (i_sample),
    .o_ready     (o_ready),
    .i_flush     (i_flush),
    .i_fft_done  (i_fft_done),
    .o_start     (o_start),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_frame_cnt (o_frame_cnt)
  );

  // Reference: partial-frame queue, FIFO of completed frames, one active slot.
  // Capacity is two frames in flight (active + waiting).
  logic [SD-1:0] part [$];
  frm_t          pend [$];
  bit            m_active, m_start, m_busy, m_ready;
  frm_t          m_data;
  logic [CW-1:0] m_cnt;

  task automatic model_reset();
    part.delete();
    pend.delete();
    m_active = 0; m_start = 0; m_busy = 0; m_ready = 0;
    m_data = '0; m_cnt = '0;
  endtask

  task automatic model_edge(input bit v, input logic [SD-1:0] s, input bit fl, input bit dn);
    bit   acc;
    bit   de;
    frm_t f;
    acc = v && m_ready && !fl;
    de  = dn && m_active && !m_start;
    if (fl) begin
      part.delete();
    end else if (acc) begin
      part.push_back(s);
      if (part.size() == NP) begin
        for (int k = 0; k < NP; k++) f[k] = part[k];
        pend.push_back(f);
        part.delete();
      end
    end
    if (de) m_active = 0;
    m_start = 0;
    if (!m_active && pend.size() > 0) begin
      m_data   = pend.pop_front();
      m_active = 1;
      m_start  = 1;
      m_cnt    = m_cnt + 1'b1;
    end
    m_ready = (int'(m_active) + pend.size()) < 2;
    m_busy  = m_active;
  endtask

  task automatic step(input bit v, input logic [SD-1:0] s, input bit fl, input bit dn, output bit acc);
    i_valid = v; i_sample = s; i_flush = fl; i_fft_done = dn;
    acc = v && m_ready && !fl;
    @(posedge clk);
    model_edge(v, s, fl, dn);
    #1;
    i_valid = 0; i_flush = 0; i_fft_done = 0;
  endtask

  task automatic do_reset();
    bit acc;
    rst_n = 0; i_valid = 0; i_flush = 0; i_fft_done = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk) rst_n = 1;
    step(0, '0, 0, 0, acc);
  endtask

  task automatic test_reset();
    bit acc;
    rst_n = 0; i_valid = 1; i_sample = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_start !== 1'b0 || o_busy !== 1'b0 || o_frame_cnt !== 2'd0 || o_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b start=%b busy=%b cnt=%0d data=%h, required all 0",
               o_ready, o_start, o_busy, o_frame_cnt, o_data);
    end
    i_valid = 0;
    model_reset();
    @(negedge clk) rst_n = 1;
    step(0, '0, 0, 0, acc);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: got %b required 1", o_ready);
    end
  endtask

  task automatic test_single_frame();
    bit   acc;
    frm_t exp_f;
    do_reset();
    for (int k = 0; k < NP; k++) begin
      exp_f[k] = SD'(k + 1);
      checks++;
      if (o_ready !== 1'b1) begin
        failures++;
        $display("FAIL single_ready[%0d]: got %b required 1", k, o_ready);
      end
      step(1, SD'(k + 1), 0, 0, acc);
      checks++;
      if (o_start !== ((k == NP - 1) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL single_start_timing[%0d]: got %b required %b", k, o_start, k == NP - 1);
      end
    end
    checks++;
    if (o_data !== exp_f || o_frame_cnt !== 2'd1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_frame: got data=%h cnt=%0d busy=%b required data=%h cnt=1 busy=1",
               o_data, o_frame_cnt, o_busy, exp_f);
    end
    for (int c = 0; c < 20; c++) begin
      step(0, '0, 0, 0, acc);
      checks++;
      if (o_busy !== 1'b1 || o_start !== 1'b0 || o_data !== exp_f) begin
        failures++;
        $display("FAIL single_hold[%0d]: got busy=%b start=%b data=%h required busy=1 start=0 data=%h",
                 c, o_busy, o_start, o_data, exp_f);
      end
    end
    step(0, '0, 0, 1, acc);
    checks++;
    if (o_busy !== 1'b0 || o_start !== 1'b0 || o_data !== exp_f) begin
      failures++;
      $display("FAIL single_done: got busy=%b start=%b data=%h required busy=0 start=0 data=%h",
               o_busy, o_start, o_data, exp_f);
    end
  endtask

  task automatic test_backpressure();
    bit   acc;
    int   n_acc;
    frm_t d;
    do_reset();
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 16; c++) begin
      step(1, SD'(32'h10 + n_acc), 0, 0, acc);
      if (acc) n_acc++;
      checks++;
      if (o_ready !== m_ready || o_start !== m_start || o_data !== m_data) begin
        failures++;
        $display("FAIL bp_fill[%0d]: got rdy=%b start=%b required rdy=%b start=%b", c, o_ready, o_start, m_ready, m_start);
      end
    end
    checks++;
    if (n_acc != 16 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_drop: got accepted=%0d rdy=%b required accepted=16 rdy=0", n_acc, o_ready);
    end
    for (int c = 0; c < 5; c++) begin
      step(1, 32'h20, 0, 0, acc);
      checks++;
      if (o_ready !== 1'b0 || o_start !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got rdy=%b start=%b required rdy=0 start=0", c, o_ready, o_start);
      end
    end
    step(1, 32'h20, 0, 1, acc);
    d = o_data;
    checks++;
    if (o_start !== 1'b1 || d[0] !== 32'h18 || o_ready !== 1'b1 || o_frame_cnt !== 2'd2 || o_data !== m_data) begin
      failures++;
      $display("FAIL bp_release: got start=%b data0=%h rdy=%b cnt=%0d required start=1 data0=18 rdy=1 cnt=2",
               o_start, d[0], o_ready, o_frame_cnt);
    end
  endtask

  task automatic test_coincident();
    bit   acc;
    frm_t fa, fb;
    do_reset();
    for (int k = 0; k < NP; k++) begin
      fa[k] = $urandom; fb[k] = $urandom;
    end
    for (int k = 0; k < NP; k++) step(1, fa[k], 0, 0, acc);
    for (int k = 0; k < NP - 1; k++) step(1, fb[k], 0, 0, acc);
    checks++;
    if (o_busy !== 1'b1 || o_data !== fa || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL coin_a_active: got busy=%b rdy=%b data=%h required busy=1 rdy=1 data=%h", o_busy, o_ready, o_data, fa);
    end
    step(1, fb[NP-1], 0, 1, acc);
    checks++;
    if (o_start !== 1'b1 || o_data !== fb || o_frame_cnt !== 2'd2 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL coin_b_start: got start=%b cnt=%0d data=%h required start=1 cnt=2 data=%h",
               o_start, o_frame_cnt, o_data, fb);
    end
    step(0, '0, 0, 1, acc);
  endtask

  task automatic test_flush();
    bit   acc;
    frm_t exp_f;
    do_reset();
    for (int k = 0; k < 5; k++) step(1, SD'(32'h50 + k), 0, 0, acc);
    step(1, 32'hEE, 1, 0, acc);
    step(0, '0, 1, 0, acc);
    checks++;
    if (o_start !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_quiet: got start=%b rdy=%b busy=%b required 0 1 0", o_start, o_ready, o_busy);
    end
    for (int k = 0; k < NP; k++) begin
      exp_f[k] = SD'(32'hA0 + k);
      step(1, SD'(32'hA0 + k), 0, 0, acc);
    end
    checks++;
    if (o_start !== 1'b1 || o_data !== exp_f || o_frame_cnt !== 2'd1) begin
      failures++;
      $display("FAIL flush_frame: got start=%b cnt=%0d data=%h required start=1 cnt=1 data=%h",
               o_start, o_frame_cnt, o_data, exp_f);
    end
    step(0, '0, 0, 1, acc);
  endtask

  task automatic test_spurious_and_async_reset();
    bit acc;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(0, '0, 0, 1, acc);
      checks++;
      if (o_busy !== 1'b0 || o_start !== 1'b0 || o_frame_cnt !== 2'd0 || o_ready !== 1'b1 || o_data !== '0) begin
        failures++;
        $display("FAIL spurious_done[%0d]: got busy=%b start=%b cnt=%0d rdy=%b required 0 0 0 1",
                 c, o_busy, o_start, o_frame_cnt, o_ready);
      end
    end
    for (int k = 0; k < NP + 3; k++) step(1, $urandom, 0, 0, acc);
    #3 rst_n = 0;
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_start !== 1'b0 || o_busy !== 1'b0 || o_frame_cnt !== 2'd0 || o_data !== '0) begin
      failures++;
      $display("FAIL async_reset: got rdy=%b start=%b busy=%b cnt=%0d data=%h required all 0",
               o_ready, o_start, o_busy, o_frame_cnt, o_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_in_reset: got %b required 0", o_ready);
    end
    @(negedge clk) rst_n = 1;
    step(0, '0, 0, 0, acc);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_post_reset: got %b required 1", o_ready);
    end
    for (int c = 0; c < 20; c++) begin
      step(0, '0, 0, 0, acc);
      checks++;
      if (o_start !== 1'b0 || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL no_start_after_reset[%0d]: got start=%b busy=%b required 0 0", c, o_start, o_busy);
      end
    end
  endtask

  task automatic test_counter_wrap();
    bit            acc;
    frm_t          snap;
    logic [CW-1:0] exp_cnt [5];
    int            gap;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < NP; k++) step(1, $urandom, 0, 0, acc);
      snap = o_data;
      checks++;
      if (o_start !== 1'b1 || o_frame_cnt !== exp_cnt[f] || o_data !== m_data) begin
        failures++;
        $display("FAIL wrap_start[%0d]: got start=%b cnt=%0d required start=1 cnt=%0d", f, o_start, o_frame_cnt, exp_cnt[f]);
      end
      gap = $urandom_range(1, 6);
      for (int g = 0; g < gap; g++) begin
        step(0, '0, 0, 0, acc);
        checks++;
        if (o_data !== snap || o_busy !== 1'b1) begin
          failures++;
          $display("FAIL wrap_stable[%0d]: got data=%h busy=%b required data=%h busy=1", f, o_data, o_busy, snap);
        end
      end
      step(0, '0, 0, 1, acc);
      checks++;
      if (o_data !== snap || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL wrap_done[%0d]: got data=%h busy=%b required data=%h busy=0", f, o_data, o_busy, snap);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 50) == 0, ($urandom % 7) == 0, acc);
      checks++;
      if (o_ready !== m_ready || o_start !== m_start || o_busy !== m_busy ||
          o_frame_cnt !== m_cnt || o_data !== m_data) begin
        failures++;
        $display("FAIL random[%0d]: got rdy=%b start=%b busy=%b cnt=%0d required rdy=%b start=%b busy=%b cnt=%0d data_eq=%b",
                 c, o_ready, o_start, o_busy, o_frame_cnt, m_ready, m_start, m_busy, m_cnt, o_data === m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_coincident();
    test_flush();
    test_spurious_and_async_reset();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fft_sample_collector.md
Name: fft_sample_collector

Overview:
- Upstream feeder for the 8-point FFT core.
- Accepts a serial stream of SIZE_DATA-bit samples over a valid/ready handshake and assembles them into NUM_POINTS-sample frames in a ping-pong (two-bank) buffer.
- Presents each completed frame as a packed vector with a 1-cycle start pulse, and holds it stable until the core reports done.
- The FFT core connects directly: o_data to i_data, o_start to i_start, and the core's o_done to i_fft_done.

Parameters:
- NUM_POINTS, 8, samples per frame; power of two, at least 2.
- SIZE_DATA, 32, bits per sample; opaque word, no arithmetic performed.
- CNT_W, 16, width of the frame counter.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream sample valid.
- i_sample  input  SIZE_DATA  upstream sample.
- o_ready  output  1  collector can accept a sample this cycle.
- i_flush  input  1  discard the partially filled frame.
- i_fft_done  input  1  FFT core finished the active frame.
- o_start  output  1  1-cycle pulse; o_data holds a new frame.
- o_data  output  [NUM_POINTS-1:0][SIZE_DATA-1:0]  active frame; index k is the k-th accepted sample.
- o_busy  output  1  a frame is in flight in the FFT core.
- o_frame_cnt  output  CNT_W  count of o_start pulses, wraps modulo 2^CNT_W.

Behaviour:
- Reset values (asynchronous, while i_rst_n=0):
  - o_ready=0, o_start=0, o_busy=0, o_data=0, o_frame_cnt=0.
  - Both banks EMPTY; write index=0; fill bank=0.
  - o_ready rises in the first cycle after reset release.
- Bank state machine, per bank: EMPTY -> FILLING -> FULL -> ACTIVE -> EMPTY.
  - EMPTY -> FILLING: on the first accepted sample.
  - FILLING -> FULL: on the NUM_POINTS-th accepted sample.
  - FULL -> ACTIVE: when its start is issued.
  - ACTIVE -> EMPTY: on i_fft_done.
- Accept rule: a sample is accepted on an edge where i_valid & o_ready & ~i_flush.
  - It is written at the current index; the index then increments.
  - At index NUM_POINTS-1 the index wraps to 0, the bank goes FULL, and the fill pointer toggles to the other bank.
- o_ready is registered. It is 1 iff the bank the fill pointer will target next cycle is EMPTY or FILLING.
  - Consequently o_ready=0 while one bank is ACTIVE and the other is FULL.
- Start issue:
  - If no bank is ACTIVE and a bank is FULL, or becomes FULL on this edge, that bank becomes ACTIVE.
  - o_start=1 for exactly the following cycle, and o_frame_cnt increments on that same edge.
  - Latency: last sample accepted at edge N -> o_start high during cycle N+1 when the core is idle.
- o_data: registered copy of the ACTIVE bank.
  - Updates only on the edge that raises o_start.
  - Held constant from then until and including the i_fft_done cycle.
  - Retains its last value when no bank is ACTIVE.
- o_busy: 1 from the o_start cycle through the i_fft_done cycle; 0 from the next cycle.
- i_fft_done with a FULL pending bank: the ACTIVE bank goes EMPTY and the pending bank goes ACTIVE, with o_start in the next cycle, so back-to-back frames run with no idle gap.
  - o_ready returns to 1 in that same next cycle.
- i_fft_done coinciding with the 8th sample of the filling bank: behaves identically; the just-completed bank is started next cycle.
- i_fft_done while nothing is ACTIVE: ignored, no state change.
- i_fft_done in the same cycle as o_start: ignored, since the core cannot finish a frame it has not started.
- i_flush:
  - Resets the write index to 0 and returns the filling bank to EMPTY.
  - A concurrent sample is dropped, flush wins.
  - FULL and ACTIVE banks, o_data and o_start are unaffected.
  - Flush with index 0 is a no-op.
- Reset mid-operation: all state is lost immediately; partial and pending frames are discarded and no o_start is issued for them.

Decomposition:
- Package fft_pkg:
  - Localparams FFT_NUM_POINTS=8, FFT_SIZE_DATA=32.
  - Typedef sample_t (logic [SIZE_DATA-1:0]).
  - Typedef frame_t (packed [NUM_POINTS-1:0] of sample_t).
  - Enum bank_state_e {EMPTY, FILLING, FULL, ACTIVE}.
  - This package is shared with FFT_8Points and the output serializer.
- One sub-module, fft_frame_bank, instantiated twice:
  - Storage plus bank state register.
  - Write enable and index inputs; start and done inputs.
  - Outputs: frame_t and bank_state_e.
- The top level holds the fill pointer, write index, ready/start logic and the counter.

Test Plan:
- Single frame: reset, then push 0x1..0x8 on consecutive cycles with the core idle.
  - o_start pulses exactly 1 cycle after the 8th accept, with o_data[k]=k+1 and o_frame_cnt=1.
  - o_busy stays high until i_fft_done is pulsed 20 cycles later.
- Backpressure: push 16 samples (0x10..0x1F) with done withheld.
  - o_ready drops after the 16th accept; the 17th sample is held off.
  - Pulse i_fft_done: o_start is next cycle with o_data[0]=0x18, and o_ready=1 in that same cycle.
- Coincident done and last sample:
  - Frame A active, 7 samples of B loaded; pulse i_fft_done in the same cycle as B's 8th sample.
  - o_start is next cycle with B's data; o_frame_cnt=2.
- Flush:
  - Load 5 samples, assert i_flush together with a 6th valid sample, then load 0xA0..0xA7.
  - The frame started is exactly 0xA0..0xA7; the flushed and dropped samples never appear.
- Spurious done and async reset:
  - i_fft_done while idle causes no change.
  - Reset asserted asynchronously mid-frame (3 samples loaded): all outputs 0 immediately, o_ready=0 during reset and 1 one cycle after release, no o_start ever follows.
- Counter wrap:
  - With CNT_W=2, run 5 frames; o_frame_cnt reads 1, 2, 3, 0, 1.
  - o_data is stable on every cycle between each o_start and its i_fft_done.
